// File: rtl/data_sram_responder_pkg.sv
// Shared constants and helpers for the data-SRAM responder: MMIO map,
// register-select enum and byte-lane merge.
package data_sram_responder_pkg;

  localparam logic [15:0] MMIO_BASE_DEF = 16'hBFAF;

  localparam logic [15:0] LED_OFF     = 16'hF000;
  localparam logic [15:0] TIMER_OFF   = 16'hF004;
  localparam logic [15:0] SCRATCH_OFF = 16'hF008;
  localparam logic [15:0] WRCNT_OFF   = 16'hF00C;
  localparam logic [15:0] CMP_OFF     = 16'hF010;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_LED,
    REG_TIMER,
    REG_SCRATCH,
    REG_WRCNT,
    REG_CMP
  } mmio_reg_e;

  function automatic mmio_reg_e mmio_decode(input logic [15:0] off);
    case (off)
      LED_OFF:     return REG_LED;
      TIMER_OFF:   return REG_TIMER;
      SCRATCH_OFF: return REG_SCRATCH;
      WRCNT_OFF:   return REG_WRCNT;
      CMP_OFF:     return REG_CMP;
      default:     return REG_NONE;
    endcase
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// Core data-SRAM bus: request (en/wen/addr/wdata) and registered rdata.
interface data_sram_responder_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_ram_be.sv
// Synchronous-read, byte-enable-write RAM with one cycle read latency.
// rdata only changes on a read request, so it holds across writes/idle.
module data_ram_be #(
  parameter int unsigned AW = 14
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    wen,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [2**AW];
  logic [31:0] r_rdata;

  // Byte-lane writes or registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (wen == '0) begin
        r_rdata <= r_mem[addr];
      end else begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (wen[i]) r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/data_sram_responder.sv
// Target side of the core data-SRAM port: byte-writable RAM plus an MMIO
// window (LED, timer, scratch, write counter, timer compare + sticky irq).
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned RAM_AW    = 14,
  parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  data_sram_responder_if.slave  bus,
  output logic [15:0]           led,
  output logic                  irq
);

  logic        w_req, w_rd, w_wr, w_mmio, w_mmio_wr, w_ram_en;
  mmio_reg_e   w_reg;
  logic [31:0] w_ram_rdata, w_mmio_rd;
  logic [15:0] w_led_nx;
  logic [31:0] w_timer_nx, w_scratch_nx, w_cmp_nx, w_wrcnt_nx;
  logic        w_irq_nx;
  logic        w_unused_addr;

  logic [15:0] r_led;
  logic [31:0] r_timer, r_scratch, r_cmp, r_wrcnt;
  logic        r_irq;
  logic        r_mmio_q;
  logic [31:0] r_mmio_rdata;

  // A request coinciding with reset is dropped entirely.
  assign w_req     = bus.data_sram_en & ~rst;
  assign w_rd      = w_req & (bus.data_sram_wen == '0);
  assign w_wr      = w_req & (bus.data_sram_wen != '0);
  assign w_mmio    = (bus.data_sram_addr[31:16] == MMIO_BASE);
  assign w_mmio_wr = w_wr & w_mmio;
  assign w_ram_en  = w_req & ~w_mmio;
  assign w_reg     = mmio_decode(bus.data_sram_addr[15:0]);
  assign w_unused_addr = ^bus.data_sram_addr[1:0];

  data_ram_be #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .en    (w_ram_en),
    .wen   (bus.data_sram_wen),
    .addr  (bus.data_sram_addr[RAM_AW+1:2]),
    .wdata (bus.data_sram_wdata),
    .rdata (w_ram_rdata)
  );

  // MMIO read mux and next-state of every MMIO register.
  always_comb begin
    w_mmio_rd    = '0;
    w_led_nx     = r_led;
    w_scratch_nx = r_scratch;
    w_cmp_nx     = r_cmp;
    w_timer_nx   = r_timer + 32'd1;
    w_wrcnt_nx   = r_wrcnt;
    w_irq_nx     = r_irq | (r_timer == r_cmp);

    case (w_reg)
      REG_LED:     w_mmio_rd = {16'h0000, r_led};
      REG_TIMER:   w_mmio_rd = r_timer;
      REG_SCRATCH: w_mmio_rd = r_scratch;
      REG_WRCNT:   w_mmio_rd = r_wrcnt;
      REG_CMP:     w_mmio_rd = r_cmp;
      default:     w_mmio_rd = '0;
    endcase

    if (w_mmio_wr) begin
      case (w_reg)
        REG_LED: begin
          if (bus.data_sram_wen[0]) w_led_nx[7:0]  = bus.data_sram_wdata[7:0];
          if (bus.data_sram_wen[1]) w_led_nx[15:8] = bus.data_sram_wdata[15:8];
        end
        REG_TIMER:   w_timer_nx   = byte_merge(r_timer, bus.data_sram_wdata, bus.data_sram_wen);
        REG_SCRATCH: w_scratch_nx = byte_merge(r_scratch, bus.data_sram_wdata, bus.data_sram_wen);
        REG_CMP: begin
          w_cmp_nx = byte_merge(r_cmp, bus.data_sram_wdata, bus.data_sram_wen);
          w_irq_nx = 1'b0;
        end
        default: ;
      endcase
    end

    if (w_wr && !w_mmio) w_wrcnt_nx = r_wrcnt + 32'd1;
  end

  // Register update. Reset parks the output select on the MMIO read
  // register (cleared to 0) so rdata reads 0 without resetting the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led        <= '0;
      r_timer      <= '0;
      r_scratch    <= '0;
      r_cmp        <= '1;
      r_wrcnt      <= '0;
      r_irq        <= 1'b0;
      r_mmio_q     <= 1'b1;
      r_mmio_rdata <= '0;
    end else begin
      r_led     <= w_led_nx;
      r_timer   <= w_timer_nx;
      r_scratch <= w_scratch_nx;
      r_cmp     <= w_cmp_nx;
      r_wrcnt   <= w_wrcnt_nx;
      r_irq     <= w_irq_nx;
      if (w_rd) begin
        r_mmio_q <= w_mmio;
        if (w_mmio) r_mmio_rdata <= w_mmio_rd;
      end
    end
  end

  assign bus.data_sram_rdata = r_mmio_q ? r_mmio_rdata : w_ram_rdata;
  assign led = r_led;
  assign irq = r_irq;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed + randomized bench for data_sram_responder with a byte-level
// reference model of the RAM and MMIO registers.
module tb_data_sram_responder;

  localparam logic [31:0] MM = 32'hBFAF_0000;

  logic        clk;
  logic        rst;
  logic [15:0] led;
  logic        irq;

  data_sram_responder_if bus ();

  data_sram_responder #(.RAM_AW(14), .MMIO_BASE(16'hBFAF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .led (led),
    .irq (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0]  m_ram [int];
  logic [15:0] m_led;
  logic [31:0] m_timer, m_cmp, m_scratch, m_wrcnt, m_rdata;
  logic        m_irq;
  logic        m_known;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic [3:0] w,
                            input logic [31:0] a, input logic [31:0] d);
    logic        mm;
    logic [15:0] off;
    int          base;
    logic [31:0] t_old;
    if (r) begin
      m_led = '0; m_timer = '0; m_cmp = '1; m_scratch = '0; m_wrcnt = '0;
      m_irq = 1'b0; m_rdata = '0; m_known = 1'b1;
      return;
    end
    mm    = (a[31:16] == 16'hBFAF);
    off   = a[15:0];
    base  = int'(a[15:2]) * 4;
    t_old = m_timer;
    if (t_old == m_cmp) m_irq = 1'b1;
    m_timer = t_old + 32'd1;
    if (e && w == 4'h0) begin
      m_known = 1'b1;
      if (mm) begin
        case (off)
          16'hF000: m_rdata = {16'h0000, m_led};
          16'hF004: m_rdata = t_old;
          16'hF008: m_rdata = m_scratch;
          16'hF00C: m_rdata = m_wrcnt;
          16'hF010: m_rdata = m_cmp;
          default:  m_rdata = '0;
        endcase
      end else begin
        for (int l = 0; l < 4; l++) begin
          if (m_ram.exists(base + l)) m_rdata[8*l +: 8] = m_ram[base + l];
          else m_known = 1'b0;
        end
      end
    end else if (e) begin
      if (mm && off == 16'hF004) m_timer = t_old;
      if (mm && off == 16'hF010) m_irq = 1'b0;
      if (!mm) m_wrcnt = m_wrcnt + 32'd1;
      for (int l = 0; l < 4; l++) begin
        if (w[l]) begin
          if (!mm) m_ram[base + l] = d[8*l +: 8];
          else case (off)
            16'hF000: if (l < 2) m_led[8*l +: 8] = d[8*l +: 8];
            16'hF004: m_timer[8*l +: 8]   = d[8*l +: 8];
            16'hF008: m_scratch[8*l +: 8] = d[8*l +: 8];
            16'hF010: m_cmp[8*l +: 8]     = d[8*l +: 8];
            default: ;
          endcase
        end
      end
    end
  endtask

  // One bus cycle: drive, clock, update model, check outputs.
  task automatic cyc(input logic r, input logic e, input logic [3:0] w,
                     input logic [31:0] a, input logic [31:0] d);
    rst = r;
    bus.data_sram_en    = e;
    bus.data_sram_wen   = w;
    bus.data_sram_addr  = a;
    bus.data_sram_wdata = d;
    @(posedge clk);
    model_step(r, e, w, a, d);
    #1;
    chk("led", 32'(led), 32'(m_led));
    chk("irq", 32'(irq), 32'(m_irq));
    if (m_known) chk("rdata", bus.data_sram_rdata, m_rdata);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    cyc(1'b0, 1'b1, w, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(1'b0, 1'b1, 4'h0, a, 32'h0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] t1;
    logic [31:0] a;
    logic [3:0]  w;
    logic [15:0] up;
    logic [15:0] offs [6];
    offs[0] = 16'hF000; offs[1] = 16'hF004; offs[2] = 16'hF008;
    offs[3] = 16'hF00C; offs[4] = 16'hF010; offs[5] = 16'hF014;

    rst = 1'b1;
    bus.data_sram_en = 1'b0; bus.data_sram_wen = '0;
    bus.data_sram_addr = '0; bus.data_sram_wdata = '0;
    m_known = 1'b0;

    cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("rst_rdata", bus.data_sram_rdata, 32'h0);
    chk("rst_led", 32'(led), 32'h0);

    // basic RAM write/read and write counter
    wr(32'h0000_0010, 32'hDEADBEEF, 4'hF);
    rd(32'h0000_0010);
    chk("ram_rd", bus.data_sram_rdata, 32'hDEADBEEF);
    rd(MM | 32'hF00C);
    chk("wrcnt_1", bus.data_sram_rdata, 32'h1);

    // byte-lane merge
    wr(32'h0000_0014, 32'h11223344, 4'hF);
    wr(32'h0000_0014, 32'hAABBCCDD, 4'b0101);
    rd(32'h0000_0014);
    chk("byte_merge", bus.data_sram_rdata, 32'h11BB33DD);

    // back-to-back write/read/read
    wr(32'h0000_0024, 32'h24242424, 4'hF);
    wr(32'h0000_0020, 32'hCAFEF00D, 4'hF);
    rd(32'h0000_0020);
    chk("b2b_a", bus.data_sram_rdata, 32'hCAFEF00D);
    rd(32'h0000_0024);
    chk("b2b_b", bus.data_sram_rdata, 32'h24242424);

    // timer increment and wrap
    wr(MM | 32'hF004, 32'hFFFF_FFFE, 4'hF);
    rd(MM | 32'hF004);
    t1 = bus.data_sram_rdata;
    chk("timer_ld", t1, 32'hFFFF_FFFE);
    rd(MM | 32'hF004);
    chk("timer_inc", bus.data_sram_rdata - t1, 32'h1);
    rd(MM | 32'hF004);
    chk("timer_wrap", bus.data_sram_rdata, 32'h0);

    // compare interrupt
    wr(MM | 32'hF010, 32'd100, 4'hF);
    wr(MM | 32'hF004, 32'd95, 4'hF);
    repeat (5) idle();
    chk("irq_pre", 32'(irq), 32'h0);
    idle();
    chk("irq_set", 32'(irq), 32'h1);
    repeat (3) idle();
    chk("irq_sticky", 32'(irq), 32'h1);
    wr(MM | 32'hF010, 32'd0, 4'hF);
    chk("irq_clr", 32'(irq), 32'h0);

    // match coinciding with CMP write: clear wins
    wr(MM | 32'hF010, 32'd300, 4'hF);
    wr(MM | 32'hF004, 32'd298, 4'hF);
    idle();
    idle();
    wr(MM | 32'hF010, 32'd500, 4'hF);
    chk("irq_coinc", 32'(irq), 32'h0);
    idle();
    chk("irq_coinc2", 32'(irq), 32'h0);

    // reset during LED write
    wr(MM | 32'hF000, 32'h0000_1234, 4'h3);
    rd(MM | 32'hF000);
    chk("led_rd", bus.data_sram_rdata, 32'h0000_1234);
    cyc(1'b1, 1'b1, 4'hF, MM | 32'hF000, 32'h0000_00FF);
    chk("rstw_led", 32'(led), 32'h0);
    chk("rstw_rdata", bus.data_sram_rdata, 32'h0);
    idle();

    // unmapped offset
    wr(MM | 32'hF008, 32'h5A5A_A5A5, 4'hF);
    wr(MM | 32'hF000, 32'hFFFF_ABCD, 4'hF);
    rd(MM | 32'hF014);
    chk("unmap_rd", bus.data_sram_rdata, 32'h0);
    wr(MM | 32'hF014, 32'hFFFF_FFFF, 4'hF);
    rd(MM | 32'hF008);
    chk("unmap_scratch", bus.data_sram_rdata, 32'h5A5A_A5A5);
    rd(MM | 32'hF000);
    chk("led_upper0", bus.data_sram_rdata, 32'h0000_ABCD);
    rd(MM | 32'hF010);
    rd(MM | 32'hF00C);
    wr(MM | 32'hF00C, 32'h1234_5678, 4'hF);
    rd(MM | 32'hF00C);

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = MM | {16'h0, offs[$urandom_range(0, 5)]};
        a[1:0] = 2'($urandom_range(0, 3));
      end else begin
        up = 16'($urandom);
        if (up == 16'hBFAF) up = 16'h0000;
        a = {up, 10'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      end
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), w, a, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
